// File: rtl/dram_rd_arb_pkg.sv
// dram_rd_arb shared types: FSM state encoding, AXI burst constants,
// and the client index type.
package dram_rd_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_SIZE_8B    = 2'b11;

  typedef logic client_t;

endpackage

// File: rtl/dram_rd_arb_rr.sv
// Two-way round-robin pick: a lone requester wins outright, and on a tie
// the client that was not granted last time wins.
module dram_rd_arb_rr
  import dram_rd_arb_pkg::*;
(
  input  logic [1:0] req,
  input  client_t    last_grant,
  output client_t    pick,
  output logic       any
);

  assign any  = |req;
  assign pick = (&req) ? ~last_grant : req[1];

endmodule

// File: rtl/dram_rd_arb.sv
// Two-client DRAM read arbiter onto one AXI read master, one burst in flight.
// Optional RRESP/RLAST error capture is enabled with DRAM_RD_ARB_ERR_EN.
module dram_rd_arb
  import dram_rd_arb_pkg::*;
#(
  parameter int BURST_BEATS = 16
) (
  input  logic        fclk,
  input  logic        rst,
  input  logic        c0_arvalid,
  input  logic [31:0] c0_araddr,
  output logic        c0_arready,
  output logic        c0_rvalid,
  output logic        c0_rlast,
  output logic [63:0] c0_rdata,
  input  logic        c0_rready,
  input  logic        c1_arvalid,
  input  logic [31:0] c1_araddr,
  output logic        c1_arready,
  output logic        c1_rvalid,
  output logic        c1_rlast,
  output logic [63:0] c1_rdata,
  input  logic        c1_rready,
  output logic        M_AXI_ACLK,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  output logic [31:0] M_AXI_ARADDR,
  output logic [1:0]  M_AXI_ARBURST,
  output logic [1:0]  M_AXI_ARSIZE,
  output logic [3:0]  M_AXI_ARLEN,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY,
  input  logic        M_AXI_RLAST,
  input  logic [63:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  output logic [1:0]  debug_state
`ifdef DRAM_RD_ARB_ERR_EN
  ,
  output logic        err_sticky,
  output logic        err_client
`endif
);

  state_e      state, state_n;
  client_t     g, g_n;
  client_t     last_grant, lg_n;
  logic [3:0]  cnt, cnt_n;
  logic [31:0] araddr, addr_n;
  logic        arvalid, arv_n;
  client_t     pick;
  logic        any;
  logic        active;
  logic        ar_hs;
  logic        in_data;
  logic        r_hs;
  logic        last_beat;
  logic        rsel;

  dram_rd_arb_rr u_rr (
    .req        ({c1_arvalid, c0_arvalid}),
    .last_grant (last_grant),
    .pick       (pick),
    .any        (any)
  );

  assign M_AXI_ACLK    = fclk;
  assign M_AXI_ARVALID = arvalid;
  assign M_AXI_ARADDR  = araddr;
  assign M_AXI_ARBURST = AXI_BURST_INCR;
  assign M_AXI_ARSIZE  = AXI_SIZE_8B;
  assign M_AXI_ARLEN   = 4'(BURST_BEATS - 1);
  assign debug_state   = state;

  // Outputs are forced quiet while rst is high so a mid-burst
  // reset hands no further beats to the clients.
  assign active    = !rst;
  assign ar_hs     = active && (state == S_ADDR) && M_AXI_ARREADY;
  assign in_data   = active && (state == S_DATA);
  assign last_beat = (cnt == 4'd0);
  assign rsel      = g ? c1_rready : c0_rready;

  assign c0_arready   = ar_hs && !g;
  assign c1_arready   = ar_hs && g;
  assign M_AXI_RREADY = in_data && rsel;
  assign r_hs         = M_AXI_RVALID && M_AXI_RREADY;

  assign c0_rvalid = in_data && !g && M_AXI_RVALID;
  assign c1_rvalid = in_data && g && M_AXI_RVALID;
  assign c0_rlast  = c0_rvalid && last_beat;
  assign c1_rlast  = c1_rvalid && last_beat;
  assign c0_rdata  = M_AXI_RDATA;
  assign c1_rdata  = M_AXI_RDATA;

  always_comb begin
    state_n = state;
    g_n     = g;
    lg_n    = last_grant;
    cnt_n   = cnt;
    addr_n  = araddr;
    arv_n   = arvalid;
    unique case (state)
      S_IDLE: begin
        if (any) begin
          g_n     = pick;
          addr_n  = pick ? c1_araddr : c0_araddr;
          arv_n   = 1'b1;
          state_n = S_ADDR;
        end
      end
      S_ADDR: begin
        if (M_AXI_ARREADY) begin
          arv_n   = 1'b0;
          cnt_n   = 4'(BURST_BEATS - 1);
          state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (r_hs) begin
          if (last_beat) begin
            lg_n    = g;
            state_n = S_IDLE;
          end else begin
            cnt_n = cnt - 4'd1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge fclk) begin
    if (rst) begin
      state      <= S_IDLE;
      g          <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= 4'd0;
      araddr     <= 32'd0;
      arvalid    <= 1'b0;
    end else begin
      state      <= state_n;
      g          <= g_n;
      last_grant <= lg_n;
      cnt        <= cnt_n;
      araddr     <= addr_n;
      arvalid    <= arv_n;
    end
  end

`ifdef DRAM_RD_ARB_ERR_EN
  logic beat_bad;

  assign beat_bad = (M_AXI_RRESP != 2'b00) ||
                    (M_AXI_RLAST != last_beat);

  always_ff @(posedge fclk) begin
    if (rst) begin
      err_sticky <= 1'b0;
      err_client <= 1'b0;
    end else if (r_hs && beat_bad && !err_sticky) begin
      err_sticky <= 1'b1;
      err_client <= g;
    end
  end
`else
  logic unused_rsp;

  assign unused_rsp = ^{M_AXI_RRESP, M_AXI_RLAST};
`endif

endmodule

// File: tb/tb_dram_rd_arb.sv
// Directed bench for dram_rd_arb (BURST_BEATS=16 and a 4-beat instance).
// Build with DRAM_RD_ARB_ERR_EN to also exercise the error capture.
module tb_dram_rd_arb;

  logic        fclk = 1'b0;
  logic        rst;
  logic        c0_arvalid, c1_arvalid;
  logic [31:0] c0_araddr, c1_araddr;
  logic        c0_rready, c1_rready;
  logic        M_AXI_ARREADY;
  logic        M_AXI_RVALID;
  logic        M_AXI_RLAST;
  logic [63:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;

  logic        c0_arready, c1_arready;
  logic        c0_rvalid, c1_rvalid;
  logic        c0_rlast, c1_rlast;
  logic [63:0] c0_rdata, c1_rdata;
  logic        M_AXI_ACLK;
  logic        M_AXI_ARVALID;
  logic [31:0] M_AXI_ARADDR;
  logic [1:0]  M_AXI_ARBURST, M_AXI_ARSIZE;
  logic [3:0]  M_AXI_ARLEN;
  logic        M_AXI_RREADY;
  logic [1:0]  debug_state;

  logic        d4_c0_arready, d4_c1_arready;
  logic        d4_c0_rvalid, d4_c1_rvalid;
  logic        d4_c0_rlast, d4_c1_rlast;
  logic [63:0] d4_c0_rdata, d4_c1_rdata;
  logic        d4_aclk;
  logic        d4_arvalid;
  logic [31:0] d4_araddr;
  logic [1:0]  d4_arburst, d4_arsize;
  logic [3:0]  d4_arlen;
  logic        d4_rready;
  logic [1:0]  d4_state;

`ifdef DRAM_RD_ARB_ERR_EN
  logic err_sticky, err_client;
  logic d4_err_sticky, d4_err_client;
`endif

  int n_chk = 0;
  int n_err = 0;
  int err_beat = -1;

  always #5 fclk = ~fclk;

  dram_rd_arb u_dut (
    .fclk          (fclk),
    .rst           (rst),
    .c0_arvalid    (c0_arvalid),
    .c0_araddr     (c0_araddr),
    .c0_arready    (c0_arready),
    .c0_rvalid     (c0_rvalid),
    .c0_rlast      (c0_rlast),
    .c0_rdata      (c0_rdata),
    .c0_rready     (c0_rready),
    .c1_arvalid    (c1_arvalid),
    .c1_araddr     (c1_araddr),
    .c1_arready    (c1_arready),
    .c1_rvalid     (c1_rvalid),
    .c1_rlast      (c1_rlast),
    .c1_rdata      (c1_rdata),
    .c1_rready     (c1_rready),
    .M_AXI_ACLK    (M_AXI_ACLK),
    .M_AXI_ARVALID (M_AXI_ARVALID),
    .M_AXI_ARREADY (M_AXI_ARREADY),
    .M_AXI_ARADDR  (M_AXI_ARADDR),
    .M_AXI_ARBURST (M_AXI_ARBURST),
    .M_AXI_ARSIZE  (M_AXI_ARSIZE),
    .M_AXI_ARLEN   (M_AXI_ARLEN),
    .M_AXI_RVALID  (M_AXI_RVALID),
    .M_AXI_RREADY  (M_AXI_RREADY),
    .M_AXI_RLAST   (M_AXI_RLAST),
    .M_AXI_RDATA   (M_AXI_RDATA),
    .M_AXI_RRESP   (M_AXI_RRESP),
    .debug_state   (debug_state)
`ifdef DRAM_RD_ARB_ERR_EN
    ,
    .err_sticky    (err_sticky),
    .err_client    (err_client)
`endif
  );

  dram_rd_arb #(.BURST_BEATS(4)) u_dut4 (
    .fclk          (fclk),
    .rst           (rst),
    .c0_arvalid    (c0_arvalid),
    .c0_araddr     (c0_araddr),
    .c0_arready    (d4_c0_arready),
    .c0_rvalid     (d4_c0_rvalid),
    .c0_rlast      (d4_c0_rlast),
    .c0_rdata      (d4_c0_rdata),
    .c0_rready     (c0_rready),
    .c1_arvalid    (c1_arvalid),
    .c1_araddr     (c1_araddr),
    .c1_arready    (d4_c1_arready),
    .c1_rvalid     (d4_c1_rvalid),
    .c1_rlast      (d4_c1_rlast),
    .c1_rdata      (d4_c1_rdata),
    .c1_rready     (c1_rready),
    .M_AXI_ACLK    (d4_aclk),
    .M_AXI_ARVALID (d4_arvalid),
    .M_AXI_ARREADY (M_AXI_ARREADY),
    .M_AXI_ARADDR  (d4_araddr),
    .M_AXI_ARBURST (d4_arburst),
    .M_AXI_ARSIZE  (d4_arsize),
    .M_AXI_ARLEN   (d4_arlen),
    .M_AXI_RVALID  (M_AXI_RVALID),
    .M_AXI_RREADY  (d4_rready),
    .M_AXI_RLAST   (M_AXI_RLAST),
    .M_AXI_RDATA   (M_AXI_RDATA),
    .M_AXI_RRESP   (M_AXI_RRESP),
    .debug_state   (d4_state)
`ifdef DRAM_RD_ARB_ERR_EN
    ,
    .err_sticky    (d4_err_sticky),
    .err_client    (d4_err_client)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge fclk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Entered one cycle after the grant edge (DUT should be in S_ADDR).
  task automatic run_burst(input bit eg, input logic [31:0] ea,
                           input int dly, input bit tog, input bit keep);
    int beats;
    int cyc;
    bit rr;
    logic [1:0] onehot;
    logic [63:0] dat;
    onehot = eg ? 2'b10 : 2'b01;
    chk("st_addr", debug_state, 2'd1);
    chk("arvalid_up", M_AXI_ARVALID, 1'b1);
    chk("araddr", M_AXI_ARADDR, ea);
    for (int i = 0; i < dly; i++) begin
      M_AXI_ARREADY = 1'b0;
      #4;
      chk("arready_wait", {c1_arready, c0_arready}, 2'b00);
      chk("araddr_hold", M_AXI_ARADDR, ea);
      chk("arvalid_hold", M_AXI_ARVALID, 1'b1);
      chk("rready_addr", M_AXI_RREADY, 1'b0);
      tick();
    end
    M_AXI_ARREADY = 1'b1;
    #4;
    chk("arready_pulse", {c1_arready, c0_arready}, onehot);
    tick();
    M_AXI_ARREADY = 1'b0;
    if (!keep) begin
      if (eg) c1_arvalid = 1'b0;
      else c0_arvalid = 1'b0;
    end
    chk("st_data", debug_state, 2'd2);
    chk("arvalid_down", M_AXI_ARVALID, 1'b0);
    beats = 0;
    cyc = 0;
    while (beats < 16 && cyc < 64) begin
      rr = tog ? (cyc % 2 == 0) : 1'b1;
      dat = {32'hDA7A_0000, 32'(beats)};
      M_AXI_RVALID = 1'b1;
      M_AXI_RDATA = dat;
      M_AXI_RLAST = (beats == 15);
      M_AXI_RRESP = (beats == err_beat) ? 2'b10 : 2'b00;
      if (eg) begin
        c1_rready = rr;
        c0_rready = 1'b1;
      end else begin
        c0_rready = rr;
        c1_rready = 1'b1;
      end
      #4;
      chk("rready", M_AXI_RREADY, rr);
      chk("rvalid", {c1_rvalid, c0_rvalid}, onehot);
      chk("rlast", {c1_rlast, c0_rlast},
          (beats == 15) ? onehot : 2'b00);
      chk("rdata", eg ? c1_rdata : c0_rdata, dat);
      tick();
      if (rr) beats++;
      cyc++;
    end
    chk("beats", 64'(beats), 64'd16);
    chk("st_idle", debug_state, 2'd0);
    chk("rready_idle", M_AXI_RREADY, 1'b0);
    chk("rvalid_idle", {c1_rvalid, c0_rvalid}, 2'b00);
    M_AXI_RVALID = 1'b0;
    M_AXI_RLAST = 1'b0;
    M_AXI_RRESP = 2'b00;
  endtask

  initial begin
    rst = 1'b1;
    c0_arvalid = 1'b0;
    c1_arvalid = 1'b0;
    c0_araddr = 32'd0;
    c1_araddr = 32'd0;
    c0_rready = 1'b0;
    c1_rready = 1'b0;
    M_AXI_ARREADY = 1'b0;
    M_AXI_RVALID = 1'b0;
    M_AXI_RLAST = 1'b0;
    M_AXI_RDATA = 64'd0;
    M_AXI_RRESP = 2'b00;
    tick();
    tick();

    chk("rst_state", debug_state, 2'd0);
    chk("rst_arvalid", M_AXI_ARVALID, 1'b0);
    chk("rst_araddr", M_AXI_ARADDR, 32'd0);
    chk("rst_rready", M_AXI_RREADY, 1'b0);
    chk("rst_arready", {c1_arready, c0_arready}, 2'b00);
    chk("arlen16", M_AXI_ARLEN, 4'd15);
    chk("arburst", M_AXI_ARBURST, 2'b01);
    chk("arsize", M_AXI_ARSIZE, 2'b11);
    rst = 1'b0;

    // c0 alone, slave ARREADY held off three cycles
    c0_arvalid = 1'b1;
    c0_araddr = 32'h1000_0000;
    #4;
    chk("lat_pre", M_AXI_ARVALID, 1'b0);
    tick();
    run_burst(1'b0, 32'h1000_0000, 3, 1'b0, 1'b0);

    // continuous tie: strict alternation from reset
    pulse_rst();
    c0_araddr = 32'h0000_0100;
    c1_araddr = 32'h0000_0900;
    c0_arvalid = 1'b1;
    c1_arvalid = 1'b1;
    tick();
    run_burst(1'b0, 32'h100, 0, 1'b0, 1'b1);
    tick();
    run_burst(1'b1, 32'h900, 1, 1'b0, 1'b1);
    tick();
    run_burst(1'b0, 32'h100, 0, 1'b0, 1'b1);
    tick();
    run_burst(1'b1, 32'h900, 2, 1'b0, 1'b0);
    c0_arvalid = 1'b0;
    tick();
    chk("stay_idle", debug_state, 2'd0);

    // c1 alone with throttled rready
    c1_arvalid = 1'b1;
    c1_araddr = 32'h0000_3000;
    tick();
    run_burst(1'b1, 32'h3000, 1, 1'b1, 1'b0);

`ifdef DRAM_RD_ARB_ERR_EN
    pulse_rst();
    chk("err_clear", err_sticky, 1'b0);
    c1_arvalid = 1'b1;
    c1_araddr = 32'h0000_4000;
    err_beat = 2;
    tick();
    run_burst(1'b1, 32'h4000, 0, 1'b0, 1'b0);
    err_beat = -1;
    chk("err_sticky", err_sticky, 1'b1);
    chk("err_client", err_client, 1'b1);
    tick();
    chk("err_hold", err_sticky, 1'b1);
`endif

    // reset in the middle of a c1 burst
    pulse_rst();
    c1_arvalid = 1'b1;
    c1_araddr = 32'h0000_5000;
    tick();
    chk("mr_addr", debug_state, 2'd1);
    M_AXI_ARREADY = 1'b1;
    tick();
    M_AXI_ARREADY = 1'b0;
    c1_arvalid = 1'b0;
    c1_rready = 1'b1;
    M_AXI_RVALID = 1'b1;
    repeat (6) tick();
    chk("mr_beat7", c1_rvalid, 1'b1);
    rst = 1'b1;
    #1;
    chk("mr_rvalid_rst", c1_rvalid, 1'b0);
    chk("mr_rready_rst", M_AXI_RREADY, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    chk("mr_state", debug_state, 2'd0);
    chk("mr_arvalid", M_AXI_ARVALID, 1'b0);
    chk("mr_rready", M_AXI_RREADY, 1'b0);
    chk("mr_rvalid", c1_rvalid, 1'b0);
    c0_araddr = 32'h0000_0100;
    c1_araddr = 32'h0000_0900;
    c0_arvalid = 1'b1;
    c1_arvalid = 1'b1;
    tick();
    chk("mr_tie_addr", M_AXI_ARADDR, 32'h100);
    M_AXI_ARREADY = 1'b1;
    #4;
    chk("mr_tie_grant", {c1_arready, c0_arready}, 2'b01);
    tick();
    M_AXI_ARREADY = 1'b0;
    c0_arvalid = 1'b0;
    c1_arvalid = 1'b0;
    M_AXI_RVALID = 1'b0;

    // four-beat instance
    pulse_rst();
    chk("arlen4", d4_arlen, 4'd3);
    c0_arvalid = 1'b1;
    c0_araddr = 32'h0000_0040;
    tick();
    chk("d4_addr_st", d4_state, 2'd1);
    chk("d4_araddr", d4_araddr, 32'h40);
    M_AXI_ARREADY = 1'b1;
    tick();
    M_AXI_ARREADY = 1'b0;
    c0_arvalid = 1'b0;
    c0_rready = 1'b1;
    M_AXI_RVALID = 1'b1;
    for (int b = 0; b < 4; b++) begin
      M_AXI_RLAST = (b == 3);
      #4;
      chk("d4_rvalid", d4_c0_rvalid, 1'b1);
      chk("d4_rlast", d4_c0_rlast, (b == 3));
      tick();
    end
    chk("d4_idle", d4_state, 2'd0);
    chk("d4_rready_idle", d4_rready, 1'b0);
    M_AXI_RVALID = 1'b0;
    M_AXI_RLAST = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dram_rd_arb.md
DRAM_RD_ARB -- requirements
Module: dram_rd_arb

Interface
REQ-001 Parameter: BURST_BEATS, 16, beats per burst (1..16); M_AXI_ARLEN = BURST_BEATS-1.
REQ-002 fclk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 c0_arvalid, c1_arvalid  in  1  client burst request; held high until its arready.
REQ-005 c0_araddr, c1_araddr  in  32  client burst start byte address.
REQ-006 c0_arready, c1_arready  out  1  client request accepted (one-cycle pulse).
REQ-007 c0_rvalid, c1_rvalid, c0_rlast, c1_rlast  out  1  routed read beat valid / final beat.
REQ-008 c0_rdata, c1_rdata  out  64  routed read data (M_AXI_RDATA fanned out).
REQ-009 c0_rready, c1_rready  in  1  client can accept a beat.
REQ-010 M_AXI_ACLK out 1 (= fclk); M_AXI_ARVALID out 1; M_AXI_ARREADY in 1; M_AXI_ARADDR out 32.
REQ-011 M_AXI_ARBURST out 2 = 2'b01; M_AXI_ARSIZE out 2 = 2'b11; M_AXI_ARLEN out 4 (constants).
REQ-012 M_AXI_RVALID in 1; M_AXI_RREADY out 1; M_AXI_RLAST in 1; M_AXI_RDATA in 64; M_AXI_RRESP in 2.
REQ-013 debug_state  out  2  current FSM state encoding.

Function
REQ-014 FSM SHALL have states S_IDLE=0, S_ADDR=1, S_DATA=2; at most one burst outstanding on the master port.
REQ-015 S_IDLE: if any cN_arvalid, grant register g SHALL be set (one request: that client; both: client != last_grant), ARADDR latched from cN_araddr, M_AXI_ARVALID registered high, go S_ADDR.
REQ-016 Latency: cN_arvalid high in cycle N -> M_AXI_ARVALID high in cycle N+1.
REQ-017 S_ADDR: M_AXI_ARVALID and M_AXI_ARADDR SHALL stay stable until M_AXI_ARREADY; in the handshake cycle c<g>_arready=1 (combinational), ARVALID cleared next cycle, beat counter loaded BURST_BEATS-1, go S_DATA.
REQ-018 cN_arready SHALL be 0 except for the granted client in the S_ADDR handshake cycle.
REQ-019 S_DATA: M_AXI_RREADY = c<g>_rready; c<g>_rvalid = M_AXI_RVALID; c<g>_rlast = M_AXI_RVALID && counter==0; non-granted client rvalid/rlast = 0.
REQ-020 Each beat handshake (RVALID && RREADY) SHALL decrement counter; handshake at counter==0 SHALL set last_grant=g and go S_IDLE.
REQ-021 Burst end is decided by counter alone; M_AXI_RLAST is not used for termination.
REQ-022 M_AXI_RREADY SHALL be 0 in S_IDLE and S_ADDR; R beats arriving then are not consumed.
REQ-023 Minimum spacing: one S_IDLE cycle between bursts; simultaneous requests alternate strictly.
REQ-024 Request withdrawal before grant is legal; request arriving during S_ADDR/S_DATA waits.

Reset
REQ-025 On rst: state S_IDLE, M_AXI_ARVALID=0, M_AXI_ARADDR=0, counter=0, g=0, last_grant=1 (client 0 wins first tie), all cN_arready/rvalid/rlast=0, M_AXI_RREADY=0.
REQ-026 Reset mid-burst SHALL abandon the burst with no further client beats; outstanding slave data is the system's responsibility.

Configuration
REQ-027 Macro DRAM_RD_ARB_ERR_EN defined: outputs err_sticky (1) and err_client (1) exist; err_sticky set on any consumed beat with RRESP!=0 or with RLAST != (counter==0), err_client records g of first error; cleared only by rst.
REQ-028 Macro undefined: ports absent, RRESP/RLAST ignored, no error logic.

Structure
REQ-029 Package dram_rd_arb_pkg SHALL hold the state enum, AXI burst/size constants, and client-index type.
REQ-030 One sub-module dram_rd_arb_rr (two-way round-robin pick from valid vector and last_grant) is natural; rest flat.

Verification
REQ-031 c0 only, addr 0x1000_0000, ARREADY delayed 3 cycles -> ARADDR stable 4 cycles, one c0_arready pulse, 16 beats to c0, c0_rlast on beat 16.
REQ-032 c0 and c1 both requesting continuously, addrs 0x100/0x900 -> grants c0,c1,c0,c1; one idle cycle between bursts.
REQ-033 c1_rready toggled 1,0 during data -> M_AXI_RREADY mirrors it; beat count still 16; c0 sees no rvalid.
REQ-034 rst asserted at beat 7 of a c1 burst -> next cycle S_IDLE, ARVALID=0, RREADY=0; next tie grants c0.
REQ-035 With DRAM_RD_ARB_ERR_EN, RRESP=2'b10 on beat 3 of c1 -> err_sticky=1, err_client=1, burst still completes 16 beats.
REQ-036 BURST_BEATS=4 -> M_AXI_ARLEN=3, c<g>_rlast on 4th beat, return to S_IDLE.
